// File: rtl/tinycpu_sequencer_if.sv
// Program-memory read bus between the sequencer (master) and instruction memory (slave).
// Read data is expected one cycle after imem_en.
interface tinycpu_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [3:0]        imem_data;

    modport master (output imem_en, output imem_addr, input imem_data);
    modport slave  (input imem_en, input imem_addr, output imem_data);
endinterface

// File: rtl/tinycpu_sequencer.sv
// Fetch/wait/execute sequencer issuing 4-bit opcodes from a small program memory.
// Optional single-step mode (PAUSE state, step input) is enabled by TINYCPU_SEQ_SINGLE_STEP_EN.
module tinycpu_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [ADDR_W-1:0] last_addr,
    tinycpu_sequencer_if.master imem,
    output logic [3:0]        instr,
    output logic              instr_valid,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic [ADDR_W:0]   exec_count
);

`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_DONE, S_PAUSE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        ir_q, ir_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            last_q   <= '0;
            addr_q   <= '0;
            ir_q     <= 4'h0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        last_d         = last_q;
        addr_d         = addr_q;
        ir_d           = ir_q;
        count_d        = count_q;
        halted_d       = halted_q;
        imem.imem_en   = 1'b0;
        imem.imem_addr = addr_q;
        instr          = 4'hF;
        instr_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pc_d     = '0;
                    count_d  = '0;
                    halted_d = 1'b0;
                    last_d   = last_addr;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                imem.imem_en   = 1'b1;
                imem.imem_addr = pc_q;
                addr_d         = pc_q;
                state_d        = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    ir_d = imem.imem_data;
                    // Opcodes 12..15 are HALT and end the run without being issued.
                    if (imem.imem_data[3:2] == 2'b11) begin
                        halted_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    instr       = ir_q;
                    instr_valid = 1'b1;
                    count_d     = count_q + 1'b1;
                    // pc stops at last_addr instead of incrementing, so it never wraps.
                    if (pc_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + 1'b1;
`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
                        state_d = S_PAUSE;
`else
                        state_d = S_FETCH;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
    assign busy = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                  (state_q == S_EXEC)  || (state_q == S_PAUSE);
`else
    assign busy = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_EXEC);
`endif
    assign done       = (state_q == S_DONE);
    assign halted     = halted_q;
    assign exec_count = count_q;

endmodule

// File: tb/tb_tinycpu_sequencer.sv
// Directed bench for tinycpu_sequencer: runs short programs from a behavioural memory,
// logs outputs per cycle (cycle 0 = cycle in which start is sampled) and checks them.
module tb_tinycpu_sequencer;

    localparam int ADDR_W = 4;
    localparam int LOG_N  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
    logic              step;
`endif
    logic [ADDR_W-1:0] last_addr;
    logic [3:0]        instr;
    logic              instr_valid;
    logic              busy;
    logic              done;
    logic              halted;
    logic [ADDR_W:0]   exec_count;

    logic [3:0]        mem [16];
    logic [3:0]        rdata = 4'h0;

    int tests = 0;
    int fails = 0;

    logic [3:0]        instr_log  [LOG_N];
    logic              valid_log  [LOG_N];
    logic              busy_log   [LOG_N];
    logic              done_log   [LOG_N];
    logic              halted_log [LOG_N];
    logic              en_log     [LOG_N];
    logic [ADDR_W-1:0] addr_log   [LOG_N];
    logic [ADDR_W:0]   count_log  [LOG_N];
    int                n_log;

    tinycpu_sequencer_if #(.ADDR_W(ADDR_W)) imem ();

    tinycpu_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .last_addr   (last_addr),
        .imem        (imem.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .exec_count  (exec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem.imem_en) rdata <= mem[imem.imem_addr];
    end
    assign imem.imem_data = rdata;

    task automatic logCycle(input int c);
        instr_log[c]  = instr;
        valid_log[c]  = instr_valid;
        busy_log[c]   = busy;
        done_log[c]   = done;
        halted_log[c] = halted;
        en_log[c]     = imem.imem_en;
        addr_log[c]   = imem.imem_addr;
        count_log[c]  = exec_count;
        n_log         = c + 1;
    endtask

    // Start pulses at cycle 0 (held through hold_to if larger); abort/reset pulse at the given cycle.
    task automatic applyStimulus(input int abort_cyc, input int reset_cyc,
                                 input int hold_to, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            start = (c == 0) || (c <= hold_to);
            abort = (c == abort_cyc);
            reset = (c == reset_cyc);
            #1;
            logCycle(c);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
    endtask

`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
    task automatic applyStepStimulus(input int step_cyc, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            start = (c == 0);
            step  = (c == step_cyc);
            #1;
            logCycle(c);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        step  = 1'b0;
    endtask
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int countValid();
        int n = 0;
        for (int i = 0; i < n_log; i++) if (valid_log[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int countValidOp(input logic [3:0] op);
        int n = 0;
        for (int i = 0; i < n_log; i++) if (valid_log[i] === 1'b1 && instr_log[i] === op) n++;
        return n;
    endfunction

    function automatic int countDone();
        int n = 0;
        for (int i = 0; i < n_log; i++) if (done_log[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int firstDone();
        for (int i = 0; i < n_log; i++) if (done_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int countFetch();
        int n = 0;
        for (int i = 0; i < n_log; i++) if (en_log[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int maxFetchAddr();
        int m = -1;
        for (int i = 0; i < n_log; i++)
            if (en_log[i] === 1'b1 && int'(addr_log[i]) > m) m = int'(addr_log[i]);
        return m;
    endfunction

    function automatic int fetchOrderErrors();
        int e = 0;
        int k = 0;
        for (int i = 0; i < n_log; i++) begin
            if (en_log[i] === 1'b1) begin
                if (int'(addr_log[i]) != k) e++;
                k++;
            end
        end
        return e;
    endfunction

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        last_addr = '0;
`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
        step      = 1'b0;
`endif
        for (int i = 0; i < 16; i++) mem[i] = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_instr", instr, 4'hF);
        checkOutput("reset_valid", instr_valid, 0);
        checkOutput("reset_en", imem.imem_en, 0);
        checkOutput("reset_addr", imem.imem_addr, 0);
        checkOutput("reset_count", exec_count, 0);
        checkOutput("reset_halted", halted, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic run {0,1,2,4}");
        mem[0] = 4'd0; mem[1] = 4'd1; mem[2] = 4'd2; mem[3] = 4'd4;
        last_addr = 4'd3;
        applyStimulus(-1, -1, 0, 20);
        checkOutput("basic_busy_c0", busy_log[0], 0);
        checkOutput("basic_busy_c1", busy_log[1], 1);
        checkOutput("basic_valid_c3", valid_log[3], 1);
        checkOutput("basic_instr_c3", instr_log[3], 0);
        checkOutput("basic_instr_c4", instr_log[4], 4'hF);
        checkOutput("basic_valid_c6", valid_log[6], 1);
        checkOutput("basic_instr_c6", instr_log[6], 1);
        checkOutput("basic_valid_c9", valid_log[9], 1);
        checkOutput("basic_instr_c9", instr_log[9], 2);
        checkOutput("basic_valid_c12", valid_log[12], 1);
        checkOutput("basic_instr_c12", instr_log[12], 4);
        checkOutput("basic_issues", countValid(), 4);
        checkOutput("basic_done_cycle", firstDone(), 13);
        checkOutput("basic_done_pulses", countDone(), 1);
        checkOutput("basic_busy_c13", busy_log[13], 0);
        checkOutput("basic_count", count_log[13], 4);
        checkOutput("basic_halted", halted_log[13], 0);

        $display("[TB] halt run {1,3,12,5}");
        mem[0] = 4'd1; mem[1] = 4'd3; mem[2] = 4'd12; mem[3] = 4'd5;
        applyStimulus(-1, -1, 0, 16);
        checkOutput("halt_issues", countValid(), 2);
        checkOutput("halt_done_cycle", firstDone(), 9);
        checkOutput("halt_done_pulses", countDone(), 1);
        checkOutput("halt_halted", halted_log[9], 1);
        checkOutput("halt_halted_hold", halted_log[14], 1);
        checkOutput("halt_count", count_log[9], 2);
        checkOutput("halt_op5_issued", countValidOp(4'd5), 0);

        $display("[TB] abort in WAIT of second instruction");
        mem[0] = 4'd0; mem[1] = 4'd1; mem[2] = 4'd2; mem[3] = 4'd4;
        applyStimulus(5, -1, 0, 16);
        checkOutput("abort_halted_cleared", halted_log[1], 0);
        checkOutput("abort_busy", busy_log[6], 0);
        checkOutput("abort_valid", valid_log[6], 0);
        checkOutput("abort_instr", instr_log[6], 4'hF);
        checkOutput("abort_count", count_log[6], 1);
        checkOutput("abort_issues", countValid(), 1);
        checkOutput("abort_done_pulses", countDone(), 0);

        $display("[TB] start and abort together in IDLE");
        applyStimulus(0, -1, 0, 6);
        checkOutput("startabort_busy", busy_log[1], 0);
        checkOutput("startabort_en", en_log[1], 0);
        checkOutput("startabort_issues", countValid(), 0);

        $display("[TB] full 16-word run");
        for (int i = 0; i < 16; i++) mem[i] = 4'd6;
        last_addr = 4'd15;
        applyStimulus(-1, -1, 0, 54);
        checkOutput("full_issues", countValid(), 16);
        checkOutput("full_done_cycle", firstDone(), 49);
        checkOutput("full_count", count_log[49], 16);
        checkOutput("full_fetches", countFetch(), 16);
        checkOutput("full_max_addr", maxFetchAddr(), 15);
        checkOutput("full_fetch_order", fetchOrderErrors(), 0);
        checkOutput("full_addr_hold", addr_log[50], 15);

        $display("[TB] reset during EXEC");
        mem[0] = 4'd0; mem[1] = 4'd1; mem[2] = 4'd2; mem[3] = 4'd4;
        last_addr = 4'd3;
        applyStimulus(-1, 6, 0, 12);
        checkOutput("rst_exec_busy", busy_log[7], 0);
        checkOutput("rst_exec_count", count_log[7], 0);
        checkOutput("rst_exec_valid", valid_log[7], 0);
        checkOutput("rst_exec_instr", instr_log[7], 4'hF);
        checkOutput("rst_exec_en", en_log[7], 0);
        checkOutput("rst_exec_addr", addr_log[7], 0);
        checkOutput("rst_exec_done", done_log[7], 0);
        checkOutput("rst_exec_halted", halted_log[7], 0);
        checkOutput("rst_exec_issues", countValid(), 2);
        checkOutput("rst_exec_done_pulses", countDone(), 0);

        $display("[TB] start held during run");
        applyStimulus(-1, -1, 13, 18);
        checkOutput("hold_issues", countValid(), 4);
        checkOutput("hold_done_cycle", firstDone(), 13);
        checkOutput("hold_done_pulses", countDone(), 1);
        checkOutput("hold_count", count_log[13], 4);
        checkOutput("hold_busy_c14", busy_log[14], 0);

`ifdef TINYCPU_SEQ_SINGLE_STEP_EN
        $display("[TB] single step, three-word program");
        mem[0] = 4'd0; mem[1] = 4'd1; mem[2] = 4'd2;
        last_addr = 4'd2;
        applyStepStimulus(8, 30);
        checkOutput("step_first_valid", valid_log[3], 1);
        checkOutput("step_paused_busy", busy_log[6], 1);
        checkOutput("step_paused_instr", instr_log[6], 4'hF);
        checkOutput("step_second_valid", valid_log[11], 1);
        checkOutput("step_second_instr", instr_log[11], 1);
        checkOutput("step_issues", countValid(), 2);
        checkOutput("step_count", count_log[20], 2);
        checkOutput("step_busy_c20", busy_log[20], 1);
        checkOutput("step_done_pulses", countDone(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tinycpu_sequencer.md
TINYCPU_SEQUENCER -- requirements
Module: tinycpu_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the program-memory address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: stop the current run.
REQ-006 The block SHALL have port last_addr, input, ADDR_W bits: address of the final program word, sampled at start.
REQ-007 The block SHALL have port imem_en, output, 1 bit: program-memory read enable.
REQ-008 The block SHALL have port imem_addr, output, ADDR_W bits: program-memory read address.
REQ-009 The block SHALL have port imem_data, input, 4 bits: read data, valid one cycle after imem_en.
REQ-010 The block SHALL have port instr, output, 4 bits: opcode to the instruction decoder.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: instr is a live instruction this cycle.
REQ-012 The block SHALL have ports busy, done and halted, outputs, 1 bit each: run in progress; one-cycle end-of-run pulse; run ended by a HALT opcode.
REQ-013 The block SHALL have port exec_count, output, ADDR_W+1 bits: instructions issued in the current or last run.

Function
REQ-014 The state machine SHALL have the states IDLE, FETCH, WAIT, EXEC and DONE.
REQ-015 In IDLE with start=1 and abort=0, the block SHALL:
- set pc=0;
- clear exec_count and halted;
- latch last_addr;
- move to FETCH.
REQ-016 In FETCH, the block SHALL drive imem_en=1 and imem_addr=pc, then move to WAIT.
REQ-017 In WAIT, the block SHALL capture imem_data into the instruction register.
- Opcode 0-11: move to EXEC.
- Opcode 12-15 (HALT): set halted=1 and move to DONE without issuing.
REQ-018 In EXEC, the block SHALL drive instr equal to the instruction register and instr_valid=1 for exactly one cycle, and increment exec_count.
- If pc equals the latched last_addr, move to DONE.
- Otherwise increment pc and move to FETCH.
REQ-019 Each issued instruction SHALL cost exactly 3 cycles; start sampled at cycle N SHALL give the first instr_valid at cycle N+3.
REQ-020 Outside EXEC, instr SHALL be 4'hF and instr_valid SHALL be 0, so the decoder asserts no enables.
REQ-021 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-022 busy SHALL be 1 in FETCH, WAIT and EXEC, and 0 in IDLE and DONE.
REQ-023 abort=1 in FETCH, WAIT or EXEC SHALL:
- move the block to IDLE on the next edge;
- suppress any pending EXEC;
- produce no done pulse;
- leave exec_count holding the count issued so far.
REQ-024 With start=1 and abort=1 together in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-025 start asserted while busy SHALL be ignored.
REQ-026 pc SHALL never wrap. last_addr = 2^ADDR_W-1 SHALL execute all 2^ADDR_W words, and exec_count SHALL reach 2^ADDR_W without overflow.
REQ-027 imem_addr SHALL hold its last value when imem_en=0.

Reset
REQ-028 reset=1 SHALL force, on the next edge and overriding every other input including mid-run:
- state=IDLE, pc=0, exec_count=0;
- halted=0, done=0, busy=0;
- imem_en=0, imem_addr=0;
- instr=4'hF, instr_valid=0.

Configuration
REQ-029 When the macro TINYCPU_SEQ_SINGLE_STEP_EN is defined:
- the block SHALL add an input port step, 1 bit;
- the block SHALL add a PAUSE state entered after every EXEC that is not the last, with busy=1 and instr=4'hF;
- PAUSE SHALL move to FETCH only on step=1;
- abort SHALL leave PAUSE to IDLE.
REQ-030 When the macro TINYCPU_SEQ_SINGLE_STEP_EN is undefined, the block SHALL have no step port and no PAUSE state, and SHALL run continuously as in REQ-018.

Verification
REQ-031 The bench SHALL cover this scenario:
- stimulus: program {0,1,2,4}, last_addr=3, start pulse;
- required response: instr_valid at cycles 3, 6, 9, 12 with instr 0, 1, 2, 4; done at cycle 13; exec_count=4; halted=0.
REQ-032 The bench SHALL cover this scenario:
- stimulus: program {1,3,12,5}, last_addr=3;
- required response: two instructions issued; done pulses; halted=1; exec_count=2; opcode 5 never issued.
REQ-033 The bench SHALL cover this scenario:
- stimulus: abort in the WAIT state of the second instruction;
- required response: IDLE next cycle; no done pulse; exec_count=1; instr=4'hF.
REQ-034 The bench SHALL cover this scenario:
- stimulus: last_addr=15 (ADDR_W=4), all words opcode 6;
- required response: 16 issues; exec_count=16; imem_addr never exceeds 15.
REQ-035 The bench SHALL cover this scenario:
- stimulus: reset in EXEC; separately, start held during a run;
- required response: reset values from REQ-028 next cycle; the held start does not restart the run.
REQ-036 The bench SHALL cover this scenario with TINYCPU_SEQ_SINGLE_STEP_EN defined:
- stimulus: three-word program, one step pulse;
- required response: exactly one further instruction issued per step pulse.
